// File: rtl/core_inst_pkg.sv
// core_inst_pkg: instruction bit positions, field widths and phase encodings shared by the responder.
package core_inst_pkg;
    localparam int INST_W  = 20;
    localparam int STRB_W  = 12;
    localparam int ADDR_W  = 4;
    localparam int PHASE_W = 3;
    localparam int BIT_SFP_HI   = 19;
    localparam int BIT_SFP_LO   = 17;
    localparam int BIT_OFIFO_RD = 16;
    localparam int BIT_QK_HI    = 15;
    localparam int BIT_QK_LO    = 12;
    localparam int BIT_P_HI     = 11;
    localparam int BIT_P_LO     = 8;
    localparam int BIT_EXECUTE  = 7;
    localparam int BIT_LOAD     = 6;
    localparam int BIT_QMEM_RD  = 5;
    localparam int BIT_QMEM_WR  = 4;
    localparam int BIT_KMEM_RD  = 3;
    localparam int BIT_KMEM_WR  = 2;
    localparam int BIT_PMEM_RD  = 1;
    localparam int BIT_PMEM_WR  = 0;
    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE, PH_QW, PH_KW, PH_LOAD, PH_EXEC, PH_DRAIN, PH_PWR, PH_SFP
    } phase_t;
endpackage

// File: rtl/sat_flag_counter.sv
// sat_flag_counter: counts cycles with inc high, raises a sticky flag at LIMIT and saturates there.
module sat_flag_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic flag
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset || clear) cnt <= '0;
        else if (inc && !flag) cnt <= cnt + 1'b1;
    assign flag = (cnt == W'(LIMIT));
endmodule

// File: rtl/core_inst_responder.sv
// core_inst_responder: registers/decodes the controller instruction bus and returns status flags.
module core_inst_responder
    import core_inst_pkg::*;
#(
    parameter int Q_DEPTH     = 16,
    parameter int K_DEPTH     = 16,
    parameter int LD_CYCLES   = 8,
    parameter int EXEC_CYCLES = 8,
    parameter int P_DEPTH     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INST_W-1:0]   inst,
    input  logic                clear,
    input  logic                ofifo_valid,
    output logic [STRB_W-1:0]   dec_strb,
    output logic [ADDR_W-1:0]   qk_addr,
    output logic [ADDR_W-1:0]   p_addr,
    output logic                q_full,
    output logic                k_full,
    output logic                ld_done,
    output logic                exec_done,
    output logic                out_wr,
    output logic                p_full,
    output logic [PHASE_W-1:0]  phase
);
    phase_t     state, state_nxt;
    logic [1:0] idle_cnt, idle_nxt;

    sat_flag_counter #(.LIMIT(Q_DEPTH))     u_q    (.clk(clk), .reset(reset), .clear(clear), .inc(inst[BIT_QMEM_WR]), .flag(q_full));
    sat_flag_counter #(.LIMIT(K_DEPTH))     u_k    (.clk(clk), .reset(reset), .clear(clear), .inc(inst[BIT_KMEM_WR]), .flag(k_full));
    sat_flag_counter #(.LIMIT(LD_CYCLES))   u_ld   (.clk(clk), .reset(reset), .clear(clear), .inc(inst[BIT_LOAD]),    .flag(ld_done));
    sat_flag_counter #(.LIMIT(EXEC_CYCLES)) u_exec (.clk(clk), .reset(reset), .clear(clear), .inc(inst[BIT_EXECUTE]), .flag(exec_done));
    sat_flag_counter #(.LIMIT(P_DEPTH))     u_p    (.clk(clk), .reset(reset), .clear(clear), .inc(inst[BIT_PMEM_WR]), .flag(p_full));

    always_ff @(posedge clk)
        if (reset || clear) begin
            state    <= PH_IDLE;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end

    // idle_cnt tracks consecutive all-zero instructions while in SFP; the 4th returns to IDLE
    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        case (state)
            PH_IDLE:  state_nxt = inst[BIT_QMEM_WR] ? PH_QW    : state;
            PH_QW:    state_nxt = inst[BIT_KMEM_WR] ? PH_KW    : state;
            PH_KW:    state_nxt = inst[BIT_LOAD]    ? PH_LOAD  : state;
            PH_LOAD:  state_nxt = inst[BIT_EXECUTE] ? PH_EXEC  : state;
            PH_EXEC:  state_nxt = exec_done         ? PH_DRAIN : state;
            PH_DRAIN: state_nxt = inst[BIT_PMEM_WR] ? PH_PWR   : state;
            PH_PWR:   state_nxt = (p_full && inst[BIT_PMEM_RD]) ? PH_SFP : state;
            PH_SFP: begin
                idle_nxt  = (inst == '0) ? idle_cnt + 2'd1 : 2'd0;
                state_nxt = (inst == '0 && idle_cnt == 2'd3) ? PH_IDLE : state;
            end
        endcase
    end

    always_ff @(posedge clk)
        if (reset || clear) begin
            dec_strb <= '0;
            qk_addr  <= '0;
            p_addr   <= '0;
            out_wr   <= 1'b0;
        end else begin
            dec_strb <= {inst[BIT_OFIFO_RD], inst[BIT_EXECUTE:BIT_PMEM_WR], inst[BIT_SFP_HI:BIT_SFP_LO]};
            qk_addr  <= inst[BIT_QK_HI:BIT_QK_LO];
            p_addr   <= inst[BIT_P_HI:BIT_P_LO];
            out_wr   <= ofifo_valid && (state == PH_EXEC || state == PH_DRAIN);
        end

    assign phase = state;
endmodule

// File: tb/tb_core_inst_responder.sv
// tb_core_inst_responder: directed decode table plus hand-written protocol sequences.
module tb_core_inst_responder;
    logic        clk = 1'b0;
    logic        reset, clear, ofifo_valid;
    logic [19:0] inst;
    logic [11:0] dec_strb;
    logic [3:0]  qk_addr, p_addr;
    logic        q_full, k_full, ld_done, exec_done, out_wr, p_full;
    logic [2:0]  phase;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [19:0] inst;
        logic        clr;
        logic [11:0] dec;
        logic [3:0]  qk;
        logic [3:0]  p;
    } vec_t;
    vec_t vecs[7];

    core_inst_responder dut (
        .clk(clk), .reset(reset), .inst(inst), .clear(clear), .ofifo_valid(ofifo_valid),
        .dec_strb(dec_strb), .qk_addr(qk_addr), .p_addr(p_addr),
        .q_full(q_full), .k_full(k_full), .ld_done(ld_done), .exec_done(exec_done),
        .out_wr(out_wr), .p_full(p_full), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {q_full, k_full, ld_done, exec_done, out_wr, p_full};
    endfunction

    initial begin
        vecs[0] = '{20'h00000, 1'b0, 12'h000, 4'h0, 4'h0};
        vecs[1] = '{20'hE0000, 1'b0, 12'h007, 4'h0, 4'h0};
        vecs[2] = '{20'h10000, 1'b0, 12'h800, 4'h0, 4'h0};
        vecs[3] = '{20'h0A5FF, 1'b0, 12'h7F8, 4'hA, 4'h5};
        vecs[4] = '{20'h53C2A, 1'b0, 12'h952, 4'h3, 4'hC};
        vecs[5] = '{20'hF0F81, 1'b0, 12'hC0F, 4'h0, 4'hF};
        vecs[6] = '{20'hFFFFF, 1'b1, 12'h000, 4'h0, 4'h0};

        reset = 1'b1; clear = 1'b0; ofifo_valid = 1'b0; inst = '0;
        step(); step();
        reset = 1'b0;
        chk("reset_flags", 32'(flags()), 0);
        chk("reset_phase", 32'(phase), 0);

        for (int i = 0; i < 7; i++) begin
            inst = vecs[i].inst; clear = vecs[i].clr;
            step();
            chk($sformatf("dec_strb[%0d]", i), 32'(dec_strb), 32'(vecs[i].dec));
            chk($sformatf("qk_addr[%0d]", i), 32'(qk_addr), 32'(vecs[i].qk));
            chk($sformatf("p_addr[%0d]", i), 32'(p_addr), 32'(vecs[i].p));
        end
        clear = 1'b0;

        // mid-run reset with busy bus
        inst = 20'h000FF; step(); step();
        reset = 1'b1; inst = 20'hFFFFF; ofifo_valid = 1'b1;
        step(); step(); step();
        chk("rst_dec", 32'(dec_strb), 0);
        chk("rst_addr", 32'({qk_addr, p_addr}), 0);
        chk("rst_flags", 32'(flags()), 0);
        chk("rst_phase", 32'(phase), 0);
        reset = 1'b0; inst = '0; ofifo_valid = 1'b0;
        step(); step();
        chk("post_rst_flags", 32'(flags()), 0);
        chk("post_rst_phase", 32'(phase), 0);

        // Q fill: flag one cycle after the 16th write, saturates on the 17th
        inst = 20'h00010;
        step();
        chk("qw_phase", 32'(phase), 1);
        for (int i = 2; i <= 15; i++) step();
        chk("q_full_15", 32'(q_full), 0);
        step();
        chk("q_full_16", 32'(q_full), 1);
        step();
        chk("q_full_17", 32'(q_full), 1);
        chk("q_phase_17", 32'(phase), 1);

        inst = 20'h00004;
        step();
        chk("kw_phase", 32'(phase), 2);
        for (int i = 2; i <= 15; i++) step();
        chk("k_full_15", 32'(k_full), 0);
        step();
        chk("k_full_16", 32'(k_full), 1);

        ofifo_valid = 1'b1; inst = '0;
        step();
        chk("out_wr_kw", 32'(out_wr), 0);

        inst = 20'h00040;
        step();
        chk("ld_phase", 32'(phase), 3);
        for (int i = 2; i <= 7; i++) step();
        chk("ld_done_7", 32'(ld_done), 0);
        step();
        chk("ld_done_8", 32'(ld_done), 1);

        inst = 20'h00080;
        step();
        chk("ex_phase", 32'(phase), 4);
        chk("out_wr_from_ld", 32'(out_wr), 0);
        step();
        chk("out_wr_ex", 32'(out_wr), 1);
        for (int i = 3; i <= 7; i++) step();
        chk("exec_done_7", 32'(exec_done), 0);
        step();
        chk("exec_done_8", 32'(exec_done), 1);
        chk("ex_phase_8", 32'(phase), 4);
        inst = '0;
        step();
        chk("drain_phase", 32'(phase), 5);
        chk("out_wr_drain", 32'(out_wr), 1);
        ofifo_valid = 1'b0;

        // P writes with walking address
        for (int i = 0; i < 8; i++) begin
            inst = (20'(i) << 8) | 20'h00001;
            step();
            chk($sformatf("p_addr_lag[%0d]", i), 32'(p_addr), i);
            if (i == 0) chk("pwr_phase", 32'(phase), 6);
            if (i == 6) chk("p_full_7", 32'(p_full), 0);
        end
        chk("p_full_8", 32'(p_full), 1);
        chk("out_wr_idle", 32'(out_wr), 0);
        inst = 20'h00002;
        step();
        chk("sfp_phase", 32'(phase), 7);
        inst = '0;
        step(); step(); step();
        chk("sfp_hold_3", 32'(phase), 7);
        step();
        chk("sfp_to_idle", 32'(phase), 0);
        chk("flags_sticky", 32'(flags()), 6'b111101);

        // clear coincident with the 16th Q write
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_flags", 32'(flags()), 0);
        inst = 20'h00010;
        for (int i = 1; i <= 15; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr16_q_full", 32'(q_full), 0);
        chk("clr16_phase", 32'(phase), 0);
        for (int i = 1; i <= 15; i++) step();
        chk("clr_restart_15", 32'(q_full), 0);
        step();
        chk("clr_restart_16", 32'(q_full), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
